input_conditioner: RTL and testbench

- Front-end stage that takes three raw, asynchronous, bouncing board inputs (two pushbuttons and one switch) and drives the clean A, B, I levels into the downstream state machine.
- Each channel is synchronised into clk, then debounced by a counter-qualified FSM.
- Each channel also produces a one-cycle rising-edge pulse for consumers that need events rather than levels.
- Channels are fully independent; no cross-channel qualification is done here.

---
 rtl/input_pkg.sv | 17 +
 rtl/debounce_channel.sv | 102 ++++++++++
 rtl/input_conditioner.sv | 46 ++++
 tb/tb_input_conditioner.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared definitions for the board-input conditioning front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package input_pkg;

  // Debounce FSM encoding: bit 1 equals the debounced level of the state.
  typedef enum logic [1:0] {
    STABLE_LO = 2'b00,
    WAIT_HI   = 2'b01,
    STABLE_HI = 2'b11,
    WAIT_LO   = 2'b10
  } db_state_e;

  // 10 ms qualification window at a 100 MHz clk.
  localparam int DEFAULT_DEBOUNCE_CYCLES = 1_000_000;

endpackage : input_pkg

// File: rtl/debounce_channel.sv
// One board input: 2-flop synchroniser, counter-qualified debounce FSM, rising-edge pulse.
// Latency: level follows a held raw change DEBOUNCE_CYCLES+2 edges after first sampling it.
// Backpressure: none; level and rise are free-running registered outputs.
module debounce_channel
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [1:0]       sync_q, sync_d;
  db_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             s;

  // Only the second synchroniser stage is ever looked at by the FSM.
  assign s = sync_q[1];

  // Next-state: synchroniser shift, debounce FSM, counter and output strobes.
  always_comb begin
    sync_d  = {sync_q[0], raw};
    state_d = state_q;
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    case (state_q)
      STABLE_LO: begin
        level_d = 1'b0;
        if (s) begin
          state_d = WAIT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          // Bounce: fall back without touching the output.
          state_d = STABLE_LO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = STABLE_HI;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      STABLE_HI: begin
        level_d = 1'b1;
        if (!s) begin
          state_d = WAIT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_d = STABLE_HI;
        end else if (cnt_q == CNT_MAX) begin
          // Falling edges are accepted silently: no pulse.
          state_d = STABLE_LO;
          level_d = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = STABLE_LO;
        level_d = 1'b0;
      end
    endcase
  end

  // State register; synchronous active-low reset drops any debounce in progress.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule : debounce_channel

// File: rtl/input_conditioner.sv
// Cleans the A/B/I board inputs into debounced levels plus rising-edge pulses.
// Latency: DEBOUNCE_CYCLES+2 clk edges from first raw sample to output change.
// Backpressure: none; three independent free-running channels.
module input_conditioner
  import input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  input  logic i_raw,
  output logic A,
  output logic B,
  output logic I,
  output logic a_rise,
  output logic b_rise,
  output logic i_rise
);

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_a (
    .clk   (clk),
    .rst   (rst),
    .raw   (a_raw),
    .level (A),
    .rise  (a_rise)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_b (
    .clk   (clk),
    .rst   (rst),
    .raw   (b_raw),
    .level (B),
    .rise  (b_rise)
  );

  debounce_channel #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_i (
    .clk   (clk),
    .rst   (rst),
    .raw   (i_raw),
    .level (I),
    .rise  (i_rise)
  );

endmodule : input_conditioner

// File: tb/tb_input_conditioner.sv
// Directed scoreboard bench for input_conditioner with DEBOUNCE_CYCLES=4.
// Latency: a held raw change shows on the outputs in the 6th sample after it is driven.
// Backpressure: none.
module tb_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic i_raw = 1'b0;
  logic A, B, I, a_rise, b_rise, i_rise;

  int n_checks = 0;
  int n_fails  = 0;

  // Expected {A,B,I,a_rise,b_rise,i_rise} for each sample, oldest first.
  logic [5:0] exp_q[$];
  string      tag_q[$];

  input_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .a_raw  (a_raw),
    .b_raw  (b_raw),
    .i_raw  (i_raw),
    .A      (A),
    .B      (B),
    .I      (I),
    .a_rise (a_rise),
    .b_rise (b_rise),
    .i_rise (i_rise)
  );

  always #5 clk = ~clk;

  // Drive one cycle of inputs on the falling edge and queue the outputs
  // expected just after the following rising edge.
  task automatic cyc(input logic r, input logic a, input logic b, input logic i,
                     input logic [5:0] e, input string tag);
    @(negedge clk);
    rst   = r;
    a_raw = a;
    b_raw = b;
    i_raw = i;
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic hold(input logic r, input logic a, input logic b, input logic i,
                      input logic [5:0] e, input int n, input string tag);
    for (int k = 0; k < n; k++) cyc(r, a, b, i, e, tag);
  endtask

  // Monitor: one output sample per cycle, compared against the scoreboard head.
  initial begin
    logic [5:0] got, want;
    string      tag;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        want = exp_q.pop_front();
        tag  = tag_q.pop_front();
        got  = {A, B, I, a_rise, b_rise, i_rise};
        n_checks++;
        if (got !== want) begin
          n_fails++;
          $display("FAIL %s: {A,B,I,ar,br,ir} got %b expected %b at %0t", tag, got, want, $time);
        end
      end
    end
  end

  initial begin
    // Reset held with all raw inputs high: everything stays 0.
    hold(1'b0, 1'b1, 1'b1, 1'b1, 6'b000000, 3, "reset_hold");
    // Release: all three channels qualify on the 6th sample and pulse once.
    hold(1'b1, 1'b1, 1'b1, 1'b1, 6'b000000, 5, "post_reset_wait");
    cyc (1'b1, 1'b1, 1'b1, 1'b1, 6'b111111,    "post_reset_rise");
    hold(1'b1, 1'b1, 1'b1, 1'b1, 6'b111000, 2, "post_reset_high");
    // Drop everything back low; no pulses on falling edges.
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b111000, 5, "all_fall_wait");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 3, "all_fall_low");

    // Clean press and release on A.
    hold(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5, "a_press_wait");
    cyc (1'b1, 1'b1, 1'b0, 1'b0, 6'b100100,    "a_press_rise");
    hold(1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 3, "a_press_held");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b100000, 5, "a_release_wait");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 3, "a_release_low");

    // Bounce on B shorter than the window: never reaches the outputs.
    cyc (1'b1, 1'b0, 1'b1, 1'b0, 6'b000000,    "b_bounce");
    cyc (1'b1, 1'b0, 1'b0, 1'b0, 6'b000000,    "b_bounce");
    cyc (1'b1, 1'b0, 1'b1, 1'b0, 6'b000000,    "b_bounce");
    cyc (1'b1, 1'b0, 1'b0, 1'b0, 6'b000000,    "b_bounce");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 8, "b_bounce_settled");

    // I bounces then settles high: qualified 6 samples after the last 0->1.
    cyc (1'b1, 1'b0, 1'b0, 1'b1, 6'b000000,    "i_bounce");
    cyc (1'b1, 1'b0, 1'b0, 1'b0, 6'b000000,    "i_bounce");
    hold(1'b1, 1'b0, 1'b0, 1'b1, 6'b000000, 5, "i_settle_wait");
    cyc (1'b1, 1'b0, 1'b0, 1'b1, 6'b001001,    "i_settle_rise");
    hold(1'b1, 1'b0, 1'b0, 1'b1, 6'b001000, 3, "i_settle_held");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b001000, 5, "i_release_wait");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 2, "i_release_low");

    // A and I together; B untouched.
    hold(1'b1, 1'b1, 1'b0, 1'b1, 6'b000000, 5, "ai_wait");
    cyc (1'b1, 1'b1, 1'b0, 1'b1, 6'b101101,    "ai_rise");
    hold(1'b1, 1'b1, 1'b0, 1'b1, 6'b101000, 3, "ai_held");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b101000, 5, "ai_release_wait");
    hold(1'b1, 1'b0, 1'b0, 1'b0, 6'b000000, 3, "ai_release_low");

    // Reset in the middle of an A debounce: count restarts from the release.
    hold(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 2, "mid_reset_pre");
    cyc (1'b0, 1'b1, 1'b0, 1'b0, 6'b000000,    "mid_reset_pulse");
    hold(1'b1, 1'b1, 1'b0, 1'b0, 6'b000000, 5, "mid_reset_restart");
    cyc (1'b1, 1'b1, 1'b0, 1'b0, 6'b100100,    "mid_reset_rise");
    hold(1'b1, 1'b1, 1'b0, 1'b0, 6'b100000, 3, "mid_reset_held");

    // Drain the scoreboard within a bounded number of cycles.
    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
        n_fails++;
        $display("FAIL drain: %0d samples pending, expected 0", exp_q.size());
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule : tb_input_conditioner
